cipher_frame_rx: RTL
====================

Name: cipher_frame_rx

Overview:
Receive-side frame decryptor for the LFSR stream-cipher path. It is the counterpart of the transmit path built around cipher_core.
- Consumes a framed ciphertext byte stream: seed byte, length byte, then payload.
- Regenerates the keystream from the in-band seed and XORs it against each payload byte.
- Delivers plaintext bytes through a small output FIFO with a valid/ready handshake and an end-of-frame marker.

Parameters:
DEPTH, 4, output FIFO entries (power of two, ≥2); each entry holds 8 data bits plus 1 last bit.

Ports:
clk  in  1  system clock; all logic is rising-edge.
rst_n  in  1  synchronous reset, active-low.
in_valid  in  1  in_data holds a valid byte.
in_ready  out  1  byte is accepted on a clk edge where in_valid && in_ready.
in_data  in  8  framed ciphertext byte.
abort  in  1  single-cycle request to drop the current frame.
out_valid  out  1  FIFO not empty.
out_ready  in  1  consumer pop; a byte is popped on out_valid && out_ready.
out_data  out  8  plaintext byte at the FIFO head.
out_last  out  1  head byte is the final byte of its frame.
busy  out  1  FSM is not in S_SEED.
frame_done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (rst_n=0 at a clk edge), including mid-frame:
  - FSM goes to S_SEED; FIFO is empty.
  - All outputs are 0: out_valid, out_data, out_last, busy, frame_done.
  - In-flight data is discarded.
- Frame format: byte0 = seed, byte1 = length N (0..255), then N ciphertext bytes.
- Keystream:
  - On seed accept, lfsr <= (seed==8'h00) ? 8'h01 : seed.
  - For payload byte i: key_i = lfsr; pt = ct ^ lfsr; then lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - The LFSR is 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, maximal length 255.
- FSM:
  - S_SEED: on accept, load the lfsr, go to S_LEN.
  - S_LEN: on accept, load remaining <= N.
    - N==0: pulse frame_done the next cycle, go to S_SEED.
    - N>0: go to S_DATA.
  - S_DATA: on accept, push {remaining==1, pt} into the FIFO, step the lfsr, decrement remaining.
    - When remaining==1: go to S_SEED and pulse frame_done the next cycle.
- in_ready:
  - S_SEED and S_LEN: in_ready = !abort.
  - S_DATA: in_ready = !abort && !fifo_full, where fifo_full is registered.
  - A push is never accepted into a full FIFO, even if a pop happens in the same cycle.
- Latency:
  - A payload byte accepted at edge t appears on out_data/out_valid after edge t, provided the FIFO was empty.
  - Header bytes never enter the FIFO.
- FIFO:
  - Same-cycle push and pop on a non-empty, non-full FIFO leaves the count unchanged.
  - A pop from an empty FIFO is ignored. Pointers wrap modulo DEPTH.
  - Bytes from consecutive frames queue back-to-back; out_last separates them.
- abort:
  - Takes priority over any input handshake in the same cycle.
  - FSM returns to S_SEED and remaining <= 0.
  - The FIFO is flushed: out_valid=0 on the next cycle. No frame_done pulse.
  - abort in S_SEED only flushes the FIFO.
- busy = (state != S_SEED). frame_done is registered and lasts exactly one cycle.

Decomposition:
- Shared package cipher_pkg holds:
  - LFSR_TAPS = 8'b1011_1000 (bits 7,5,4,3).
  - SEED_ZERO_SUB = 8'h01.
  - The state encoding: S_SEED=2'd0, S_LEN=2'd1, S_DATA=2'd2.
  - A function lfsr_next(8-bit) that cipher_core can reuse.
- One sub-module, byte_fifo (parameter DEPTH, width 9, synchronous reset and flush, registered full/empty).
- The FSM and keystream logic stay in cipher_frame_rx.

Test Plan:
1. Basic frame: stream 0x2B,0x03,0x48,0x3F,0xDF with out_ready=1 -> out_data 0x63,0x69,0x72 ("cir"); out_last only on 0x72; one frame_done pulse. The keystream is 0x2B,0x56,0xAD.
2. Zero seed: 0x00,0x01,0x01 -> out_data 0x00 with out_last=1, since the key is substituted to 0x01.
3. Empty frame: 0x2B,0x00 -> no FIFO write; frame_done pulses once; busy falls; the next byte is treated as a seed.
4. Backpressure, DEPTH=4: out_ready=0, frame seed 0x2B, N=6, in_valid held high.
   - in_ready drops after 4 payload bytes; the FIFO holds 0x63^... entries in order.
   - Raising out_ready drains all 6 bytes in order with no loss or duplication.
5. Abort mid-frame: assert abort after the 2nd payload byte with in_valid=1 in the same cycle.
   - That byte is not accepted; the FIFO empties the next cycle; no frame_done.
   - A following frame 0x2B,0x03,0x48,0x3F,0xDF decodes to "cir".
6. Reset mid-frame: drive rst_n=0 for one edge during S_DATA with a non-empty FIFO -> all outputs 0, busy=0; a following frame decodes correctly.

Source files
------------

// File: rtl/cipher_frame_rx_pkg.sv
// Shared definitions for the LFSR stream-cipher path (transmit and receive).
package cipher_pkg;

  // Feedback taps for x^8+x^6+x^5+x^4+1 in Fibonacci form: bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS     = 8'b1011_1000;
  // An all-zero seed would lock the LFSR, so it is replaced by this value
  localparam logic [7:0] SEED_ZERO_SUB = 8'h01;

  typedef enum logic [1:0] {
    S_SEED = 2'd0,
    S_LEN  = 2'd1,
    S_DATA = 2'd2
  } rx_state_t;

  // One keystream step: shift left, feed the XOR of the tapped bits into bit 0
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/cipher_frame_rx_byte_fifo.sv
// Small synchronous FIFO with flush; full/empty are registered so that
// upstream ready logic sees a clean flop output.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is refused even when a pop happens alongside it
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is forced to zero while empty so stale entries never leak out
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count - 1'b1;
    end
  end

  // Pointers, count and flags; reset and flush both empty the FIFO
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == (AW + 1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage array; contents need no reset because rdata is gated by empty
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/cipher_frame_rx.sv
// Receive-side frame decryptor: parses seed/length/payload, regenerates the
// keystream from the in-band seed and queues plaintext bytes for the consumer.
module cipher_frame_rx #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       abort,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic       frame_done
);

  import cipher_pkg::*;

  rx_state_t  state;
  rx_state_t  state_next;
  logic [7:0] lfsr;
  logic [7:0] remaining;
  logic       accept;
  logic       push;
  logic       done_next;
  logic       fifo_full;
  logic       fifo_empty;
  logic [8:0] fifo_head;

  // Next-state, handshake and completion decode; abort overrides everything
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    push       = 1'b0;
    done_next  = 1'b0;
    case (state)
      S_SEED: begin
        in_ready = !abort;
        accept   = in_valid && in_ready;
        if (accept) begin
          state_next = S_LEN;
        end
      end
      S_LEN: begin
        in_ready = !abort;
        accept   = in_valid && in_ready;
        if (accept) begin
          if (in_data == 8'd0) begin
            done_next  = 1'b1;
            state_next = S_SEED;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        in_ready = !abort && !fifo_full;
        accept   = in_valid && in_ready;
        if (accept) begin
          push = 1'b1;
          if (remaining == 8'd1) begin
            done_next  = 1'b1;
            state_next = S_SEED;
          end
        end
      end
      default: begin
        state_next = S_SEED;
      end
    endcase
    if (abort) begin
      state_next = S_SEED;
    end
  end

  // State register and the registered one-cycle completion pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_SEED;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= done_next;
    end
  end

  // Keystream generator and payload byte counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr      <= 8'h00;
      remaining <= 8'd0;
    end else if (abort) begin
      remaining <= 8'd0;
    end else if (accept) begin
      case (state)
        S_SEED: lfsr <= (in_data == 8'h00) ? SEED_ZERO_SUB : in_data;
        S_LEN:  remaining <= in_data;
        S_DATA: begin
          lfsr      <= lfsr_next(lfsr);
          remaining <= remaining - 8'd1;
        end
        default: begin
          lfsr <= lfsr;
        end
      endcase
    end
  end

  byte_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(9)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (push),
    .wdata ({remaining == 8'd1, in_data ^ lfsr}),
    .pop   (out_ready),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[7:0];
  assign out_last  = fifo_head[8];
  assign busy      = (state != S_SEED);

endmodule
